// File: rtl/cond_pkg.sv
// Shared definitions for the execute-stage condition unit: ARM condition
// encodings and bit positions inside the {N,Z,C,V} flag vector.
package cond_pkg;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition-code evaluator: decides whether an instruction
// with condition Cond executes under the architectural flags.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       pass
);

    logic n, z, c, v;

    assign n = Flags[FLAG_N];
    assign z = Flags[FLAG_Z];
    assign c = Flags[FLAG_C];
    assign v = Flags[FLAG_V];

    always_comb begin
        // NOTE: pass gets a value before the case so no path can leave it unassigned (no latch).
        pass = 1'b1;
        case (Cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            default: pass = 1'b1;  // AL, and 4'hF treated as unconditional
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Execute-stage condition unit: decode->execute control register, NZCV flag
// register, gated write strobes and saturating executed/skipped counters.
module cond_unit
    import cond_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             D_Valid,
    input  logic [3:0]       D_Cond,
    input  logic [1:0]       D_FlagW,
    input  logic             D_PCS,
    input  logic             D_RegW,
    input  logic             D_MemW,
    input  logic             D_NoWrite,
    input  logic             Stall,
    input  logic             Flush,
    input  logic [3:0]       ALUFlags,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             CondEx,
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] ExecCnt,
    output logic [CNT_W-1:0] SkipCnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic       E_Valid;
    logic [3:0] E_Cond;
    logic [1:0] E_FlagW;
    logic       E_PCS, E_RegW, E_MemW, E_NoWrite;
    logic       pass;
    logic       retire;

    cond_check u_cond_check (
        .Cond  (E_Cond),
        .Flags (Flags),
        .pass  (pass)
    );

    assign CondEx   = E_Valid & pass;
    assign PCSrc    = E_PCS & CondEx;
    assign RegWrite = E_RegW & ~E_NoWrite & CondEx;
    assign MemWrite = E_MemW & CondEx;
    assign retire   = E_Valid & ~Stall & ~Flush;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            E_Valid   <= 1'b0;
            E_Cond    <= 4'h0;
            E_FlagW   <= 2'b00;
            E_PCS     <= 1'b0;
            E_RegW    <= 1'b0;
            E_MemW    <= 1'b0;
            E_NoWrite <= 1'b0;
        end else if (Flush) begin
            E_Valid <= 1'b0;
        end else if (!Stall) begin
            E_Valid   <= D_Valid;
            E_Cond    <= D_Cond;
            E_FlagW   <= D_FlagW;
            E_PCS     <= D_PCS;
            E_RegW    <= D_RegW;
            E_MemW    <= D_MemW;
            E_NoWrite <= D_NoWrite;
        end
    end

    // Flags and counters move only when the execute instruction actually leaves the stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            Flags   <= 4'h0;
            ExecCnt <= '0;
            SkipCnt <= '0;
        end else if (retire) begin
            if (CondEx) begin
                if (E_FlagW[1]) Flags[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
                if (E_FlagW[0]) Flags[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
                if (ExecCnt != CNT_MAX) ExecCnt <= ExecCnt + 1'b1;
            end else begin
                if (SkipCnt != CNT_MAX) SkipCnt <= SkipCnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/cond_unit.md
# cond_unit

Execute-stage condition unit that sits directly downstream of the ALU. It holds the decode→execute pipeline register for an instruction's condition and write-enable controls, and evaluates the 4-bit ARM condition code against the architectural NZCV flag register. It gates the PC, register-file and memory write strobes and updates the flag register from the ALU's `ALUFlags` output. It also keeps saturating counts of executed and condition-failed instructions.

## Interface
Parameters:
- `CNT_W`, 16: width of each statistics counter.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `D_Valid`  in  1  decode-stage instruction valid.
- `D_Cond`  in  4  condition field, instr[31:28].
- `D_FlagW`  in  2  flag write request: [1] = N,Z; [0] = C,V.
- `D_PCS`, `D_RegW`, `D_MemW`, `D_NoWrite`  in  1 each  decoded control bits.
- `Stall`  in  1  hold the execute stage; nothing retires.
- `Flush`  in  1  discard the execute-stage instruction.
- `ALUFlags`  in  4  {N,Z,C,V} from the ALU for the execute-stage instruction.
- `PCSrc`, `RegWrite`, `MemWrite`  out  1 each  gated strobes for the execute-stage instruction.
- `CondEx`  out  1  condition passed and the execute stage is valid.
- `Flags`  out  4  architectural {N,Z,C,V}.
- `ExecCnt`, `SkipCnt`  out  CNT_W  retired-executed and retired-skipped counts.

## Operation
- **Execute register.** Holds `E_Valid`, `E_Cond`, `E_FlagW`, `E_PCS`, `E_RegW`, `E_MemW` and `E_NoWrite`.
  - On each edge: if `Flush`, set `E_Valid` to 0. Otherwise, if `~Stall`, load all fields from the `D_*` inputs. Otherwise hold.
- **Condition evaluation.** Combinational, from `E_Cond` and `Flags`:
  - 0 EQ: Z. 1 NE: ~Z. 2 CS: C. 3 CC: ~C. 4 MI: N. 5 PL: ~N. 6 VS: V. 7 VC: ~V.
  - 8 HI: C&~Z. 9 LS: ~C|Z.
  - A GE: N==V. B LT: N!=V. C GT: ~Z&(N==V). D LE: Z|(N!=V).
  - E AL: 1. F: 1 (treated as unconditional).
- **Output gating.**
  - `CondEx` = `E_Valid` & pass.
  - `PCSrc` = `E_PCS` & `CondEx`.
  - `RegWrite` = `E_RegW` & ~`E_NoWrite` & `CondEx`.
  - `MemWrite` = `E_MemW` & `CondEx`.
- **Retire.** An instruction retires when `E_Valid` & ~`Stall` & ~`Flush`.
  - On retire with `CondEx`: if `E_FlagW[1]`, load `Flags[3:2]` from `ALUFlags[3:2]`; if `E_FlagW[0]`, load `Flags[1:0]` from `ALUFlags[1:0]`. Increment `ExecCnt`.
  - On retire with ~`CondEx`: no flag change. Increment `SkipCnt`.
- **Counters.** Saturate at all-ones; they never wrap.
- **Flag bypass.** None. The next instruction's condition sees the updated flags in the cycle after the writer retires; the pipeline structure makes this sufficient.

## Timing
- **Reset values.** Reset is asynchronous and clears `E_Valid`, all E-fields, `Flags`, `ExecCnt` and `SkipCnt` to 0. All strobes and `CondEx` therefore read 0 during and directly after reset.
- **Latency.**
  - D-inputs reach the strobes 1 cycle after capture.
  - Flag update is visible on `Flags` 1 cycle after the writer is in the execute stage.
- **Held instruction.** While `Stall`=1, the execute instruction's strobes stay asserted each cycle; flags and counters do not change. A repeated evaluation therefore cannot observe its own flag write.
- **Flush priority.** `Flush`&`Stall` together: `Flush` wins. The instruction is discarded with no flag write and no count, and `E_Valid`=0 on the next cycle.
- **Partial flag write.** `E_FlagW`=2'b10 preserves C,V; 2'b01 preserves N,Z.
- **Reset mid-operation.** The in-flight instruction is lost, and flags return to 0000 (EQ fails, NE passes).

## Structure
- Shared package `cond_pkg`:
  - localparams for the 16 condition codes (`COND_EQ` … `COND_AL`);
  - flag bit indices `FLAG_N`=3, `FLAG_Z`=2, `FLAG_C`=1, `FLAG_V`=0.
- One combinational sub-module, `cond_check` (inputs `Cond`[4] and `Flags`[4]; output `pass`), so the evaluation table can be unit-tested in isolation.
- The pipeline register, flag register and counters stay in `cond_unit`.

## Test plan
- **Reset.** Assert `reset_n`=0 mid-cycle → all outputs 0 immediately. Release, apply `D_Cond`=0 (EQ) with `D_RegW`=1 → `RegWrite`=0; `SkipCnt`=1 after retire.
- **Flag set then conditional.** `D_FlagW`=11 with `ALUFlags`=0100 (Z) → `Flags`=0100. The next instruction EQ with `D_MemW`=1 → `MemWrite`=1 and `ExecCnt` increments. A NE instruction → `MemWrite`=0.
- **Partial write.** Start from `Flags`=1010. `D_FlagW`=01, `ALUFlags`=0101 → `Flags`=1001.
- **Signed compare.** `Flags`=1000 (N, ~V): GE → skip; LT → `PCSrc`=1 when `D_PCS`=1; GT → skip; LE → pass.
- **Stall/flush.** Hold an AL instruction with `D_FlagW`=11 under `Stall` for 3 cycles → `RegWrite` high for 3 cycles, then `Flags` updates once and `ExecCnt`+1. Assert `Flush`&`Stall` on an AL instruction with `D_FlagW`=11 → no flag change, counters unchanged.
- **Saturation.** `CNT_W`=4: retire 20 AL instructions → `ExecCnt`=15 and holds.
